// File: rtl/fmul_seq_pkg.sv
// Shared FP number model for the multiply/divide pair: field layout,
// bias, saturation magnitude and the multiplier FSM encoding.
package fmul_seq_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] man;
    } fp32_t;

    localparam int          EXP_BIAS   = 127;
    localparam int          MAN_W      = 23;
    localparam logic [30:0] FP_SAT_MAG = 31'h7FFFFFFF;

    typedef enum logic [1:0] {FM_IDLE, FM_MUL, FM_NORM, FM_DONE} fmul_state_e;

    // Magnitude zero; the sign bit does not matter for the fast path.
    function automatic logic is_zero(fp32_t x);
        return (x.exp == 8'h00) && (x.man == '0);
    endfunction

endpackage

// File: rtl/fmul_seq_if.sv
// Operand/result handshake bundle between an FPU issuer and fmul_seq.
interface fmul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] first_operand;
    logic [31:0] second_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] calculation_output;
    logic        busy;

    modport master (
        output in_valid, first_operand, second_operand, out_ready,
        input  in_ready, out_valid, calculation_output, busy
    );

    modport slave (
        input  in_valid, first_operand, second_operand, out_ready,
        output in_ready, out_valid, calculation_output, busy
    );
endinterface

// File: rtl/fmul_seq_mant.sv
// 24x24 unsigned shift-add mantissa multiplier, RADIX_BITS multiplier bits
// per cycle, LSB first. 'done' is high during the final iteration cycle, so
// the full product is on product_hi from the following cycle onward.
module fp_mant_mul_seq #(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] mcand,
    input  logic [23:0] mplier,
    output logic        done,
    output logic [24:0] product_hi   // P[47:23]; lower bits are truncated away
);
    localparam int N_ITER = 24 / RADIX_BITS;

    logic [47:0] acc, acc_nxt;
    logic [47:0] mcand_q;
    logic [23:0] mplier_q;
    logic [4:0]  cnt;
    logic        active;

    // Add this cycle's RADIX_BITS partial products into the accumulator.
    always_comb begin
        acc_nxt = acc;
        for (int j = 0; j < RADIX_BITS; j++) begin
            if (mplier_q[j]) acc_nxt = acc_nxt + (mcand_q << j);
        end
    end

    // Operand shift registers, accumulator and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt      <= '0;
            active   <= 1'b0;
        end else if (start) begin
            acc      <= '0;
            mcand_q  <= {24'h0, mcand};
            mplier_q <= mplier;
            cnt      <= '0;
            active   <= 1'b1;
        end else if (active) begin
            acc      <= acc_nxt;
            mcand_q  <= mcand_q << RADIX_BITS;
            mplier_q <= mplier_q >> RADIX_BITS;
            cnt      <= cnt + 5'd1;
            if (done) active <= 1'b0;
        end
    end

    assign done       = active && (cnt == 5'(N_ITER - 1));
    assign product_hi = acc[47:23];
endmodule

// File: rtl/fmul_seq.sv
// Multi-cycle single-precision multiplier: FSM, sign/exponent path,
// normalisation/classification and the registered result.
module fmul_seq
    import fmul_seq_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic         clk,
    input  logic         rst,
    fmul_seq_if.slave    bus
);
    fmul_state_e state, state_nxt;

    fp32_t a, b;
    logic  accept, op_zero, mul_start, mul_done;
    logic  [24:0] prod_hi;

    logic              sign_q;
    logic signed [9:0] exp_q, exp_norm;
    logic [22:0]       man_norm;
    logic [31:0]       res_norm, res_q;

    assign a         = bus.first_operand;
    assign b         = bus.second_operand;
    assign accept    = bus.in_valid && bus.in_ready;
    assign op_zero   = is_zero(a) || is_zero(b);
    assign mul_start = accept && !op_zero;

    fp_mant_mul_seq #(.RADIX_BITS(RADIX_BITS)) u_mant (
        .clk        (clk),
        .rst        (rst),
        .start      (mul_start),
        .mcand      ({1'b1, a.man}),
        .mplier     ({1'b1, b.man}),
        .done       (mul_done),
        .product_hi (prod_hi)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= FM_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: zero operands skip straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            FM_IDLE: if (accept) state_nxt = op_zero ? FM_DONE : FM_MUL;
            FM_MUL:  if (mul_done) state_nxt = FM_NORM;
            FM_NORM: state_nxt = FM_DONE;
            FM_DONE: if (bus.out_ready) state_nxt = FM_IDLE;
            default: state_nxt = FM_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.in_ready  = (state == FM_IDLE);
        bus.busy      = (state != FM_IDLE);
        bus.out_valid = (state == FM_DONE);
    end

    // Sign and biased exponent sum captured at accept; 10-bit signed so
    // underflow and overflow are both visible without wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
        end else if (accept) begin
            sign_q <= a.sign ^ b.sign;
            exp_q  <= $signed({2'b00, a.exp}) + $signed({2'b00, b.exp})
                      - 10'sd127;
        end
    end

    // Normalise on P[47] and classify into underflow / saturate / normal.
    always_comb begin
        exp_norm = exp_q + $signed({9'h0, prod_hi[24]});
        man_norm = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
        if (exp_norm <= 10'sd0)
            res_norm = {sign_q, 31'h0};
        else if (exp_norm >= 10'sd255)
            res_norm = {sign_q, FP_SAT_MAG};
        else
            res_norm = {sign_q, exp_norm[7:0], man_norm};
    end

    // Result register: loaded on the zero fast path or at NORM, else held.
    always_ff @(posedge clk) begin
        if (rst)
            res_q <= 32'h0;
        else if (accept && op_zero)
            res_q <= {a.sign ^ b.sign, 31'h0};
        else if (state == FM_NORM)
            res_q <= res_norm;
    end

    assign bus.calculation_output = res_q;
endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench: a RADIX_BITS=1 and a RADIX_BITS=4 instance run the
// same operand stream against an arithmetic reference model.
module tb_fmul_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmul_seq_if b1();
    fmul_seq_if b4();

    assign b4.in_valid       = b1.in_valid;
    assign b4.first_operand  = b1.first_operand;
    assign b4.second_operand = b1.second_operand;
    assign b4.out_ready      = b1.out_ready;

    fmul_seq #(.RADIX_BITS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    fmul_seq #(.RADIX_BITS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: real-valued product of the two mantissas as a 48-bit integer.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        longint unsigned ma, mb, p;
        int e;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:0] == 0 || b[30:0] == 0) return {s, 31'h0};
        ma = 64'h800000 + 64'(a[22:0]);
        mb = 64'h800000 + 64'(b[22:0]);
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= 64'h8000_0000_0000) begin
            e = e + 1;
            m = 23'(p >> 24);
        end else begin
            m = 23'(p >> 23);
        end
        if (e <= 0)   return {s, 31'h0};
        if (e >= 255) return {s, 31'h7FFFFFFF};
        return {s, 8'(e), m};
    endfunction

    // Issue one op to both instances and collect results and latencies
    // (edges from accept to the first edge that sees out_valid; -1 = timeout).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r1, output logic [31:0] r4,
                         output int l1, output int l4);
        @(negedge clk);
        b1.in_valid = 1'b1; b1.first_operand = a; b1.second_operand = b;
        b1.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b1.in_valid = 1'b0;
        b1.first_operand = $urandom; b1.second_operand = $urandom;
        l1 = -1; l4 = -1; r1 = 'x; r4 = 'x;
        for (int c = 1; c <= 100; c++) begin
            if (l1 < 0 && b1.out_valid) begin l1 = c; r1 = b1.calculation_output; end
            if (l4 < 0 && b4.out_valid) begin l4 = c; r4 = b4.calculation_output; end
            if (l1 >= 0 && l4 >= 0) break;
            @(negedge clk);
        end
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b1.in_valid = 1'b0; b1.out_ready = 1'b0;
        b1.first_operand = '0; b1.second_operand = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (b1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid r1: got %b want 0", b1.out_valid); end
        n_chk++; if (b1.calculation_output !== 32'h0) begin n_fail++; $display("FAIL reset_output r1: got %h want 0", b1.calculation_output); end
        n_chk++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy r1: got %b want 0", b1.busy); end
        n_chk++; if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready r1: got %b want 1", b1.in_ready); end
        n_chk++; if (b4.out_valid !== 1'b0 || b4.busy !== 1'b0 || b4.in_ready !== 1'b1 || b4.calculation_output !== 32'h0) begin
            n_fail++; $display("FAIL reset_r4: ov=%b busy=%b rdy=%b out=%h want 0/0/1/0", b4.out_valid, b4.busy, b4.in_ready, b4.calculation_output);
        end
    endtask

    // Directed vectors with constants taken from hand calculation.
    task automatic test_directed();
        logic [31:0] va[6] = '{32'h40000000, 32'h3FC00000, 32'h80000000, 32'h7F000000, 32'h00800000, 32'h80800000};
        logic [31:0] vb[6] = '{32'h40400000, 32'hBFC00000, 32'h40000000, 32'h7F000000, 32'h00800000, 32'h00800000};
        logic [31:0] ve[6] = '{32'h40C00000, 32'hC0100000, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h80000000};
        int  el1[6] = '{26, 26, 1, 26, 26, 26};
        int  el4[6] = '{8, 8, 1, 8, 8, 8};
        logic [31:0] r1, r4;
        int l1, l4;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], r1, r4, l1, l4);
            n_chk++; if (r1 !== ve[i]) begin n_fail++; $display("FAIL directed%0d_result r1: got %h want %h", i, r1, ve[i]); end
            n_chk++; if (r4 !== ve[i]) begin n_fail++; $display("FAIL directed%0d_result r4: got %h want %h", i, r4, ve[i]); end
            n_chk++; if (l1 != el1[i]) begin n_fail++; $display("FAIL directed%0d_latency r1: got %0d want %0d", i, l1, el1[i]); end
            n_chk++; if (l4 != el4[i]) begin n_fail++; $display("FAIL directed%0d_latency r4: got %0d want %0d", i, l4, el4[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, exp_r, r1, r4;
        int l1, l4;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom;
            if (a[30:23] == 8'h00) a[22:0] = '0;
            if (b[30:23] == 8'h00) b[22:0] = '0;
            if (i % 7 == 3) b[30:0] = '0;
            exp_r = model(a, b);
            do_op(a, b, r1, r4, l1, l4);
            n_chk++; if (r1 !== exp_r || r4 !== exp_r) begin
                n_fail++; $display("FAIL random%0d_result %h*%h: r1=%h r4=%h want %h", i, a, b, r1, r4, exp_r);
            end
            n_chk++; if (l1 != (b[30:0] == 0 ? 1 : 26) || l4 != (b[30:0] == 0 ? 1 : 8)) begin
                n_fail++; $display("FAIL random%0d_latency: r1=%0d r4=%0d", i, l1, l4);
            end
        end
    endtask

    // Results held while the consumer stalls; new requests ignored.
    task automatic test_stall();
        logic [31:0] a = 32'h3FC00000, b = 32'h40400000, exp_r;
        int got;
        exp_r = model(a, b);
        @(negedge clk);
        b1.in_valid = 1'b1; b1.first_operand = a; b1.second_operand = b; b1.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b1.in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 100; c++) begin
            if (b1.out_valid && b4.out_valid) begin got = 1; break; end
            @(negedge clk);
        end
        n_chk++; if (got != 1) begin n_fail++; $display("FAIL stall_wait: out_valid never seen, got %0d want 1", got); end
        for (int k = 0; k < 10; k++) begin
            b1.in_valid = 1'b1; b1.first_operand = $urandom; b1.second_operand = $urandom;
            @(negedge clk);
            n_chk++; if (b1.out_valid !== 1'b1 || b1.calculation_output !== exp_r || b1.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall%0d r1: ov=%b out=%h rdy=%b want 1/%h/0", k, b1.out_valid, b1.calculation_output, b1.in_ready, exp_r);
            end
            n_chk++; if (b4.out_valid !== 1'b1 || b4.calculation_output !== exp_r || b4.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall%0d r4: ov=%b out=%h rdy=%b want 1/%h/0", k, b4.out_valid, b4.calculation_output, b4.in_ready, exp_r);
            end
        end
        b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
        n_chk++; if (b1.busy !== 1'b0 || b1.in_ready !== 1'b1 || b4.busy !== 1'b0 || b4.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: busy1=%b rdy1=%b busy4=%b ov4=%b want 0/1/0/0", b1.busy, b1.in_ready, b4.busy, b4.out_valid);
        end
    endtask

    // Reset mid-multiply drops the op; the next op is unaffected.
    task automatic test_reset_mid();
        logic [31:0] r1, r4, exp_r;
        int l1, l4;
        @(negedge clk);
        b1.in_valid = 1'b1; b1.first_operand = 32'h40490FDB; b1.second_operand = 32'h402DF854;
        @(posedge clk);
        @(negedge clk);
        b1.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        n_chk++; if (b1.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre busy r1: got %b want 1", b1.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (b1.out_valid !== 1'b0 || b1.busy !== 1'b0 || b1.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst r1: ov=%b busy=%b rdy=%b want 0/0/1", b1.out_valid, b1.busy, b1.in_ready);
        end
        n_chk++; if (b4.out_valid !== 1'b0 || b4.busy !== 1'b0 || b4.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst r4: ov=%b busy=%b rdy=%b want 0/0/1", b4.out_valid, b4.busy, b4.in_ready);
        end
        exp_r = model(32'hC1200000, 32'h3E800000);
        do_op(32'hC1200000, 32'h3E800000, r1, r4, l1, l4);
        n_chk++; if (r1 !== exp_r || r4 !== exp_r || exp_r !== 32'hC0200000) begin
            n_fail++; $display("FAIL midrst_next: r1=%h r4=%h model=%h want C0200000", r1, r4, exp_r);
        end
        n_chk++; if (l1 != 26 || l4 != 8) begin n_fail++; $display("FAIL midrst_next_latency: r1=%0d r4=%0d want 26/8", l1, l4); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
